ps2_keycode_receiver: RTL and testbench

Deserialises PS/2 keyboard frames (set-2 scancodes) from the keyboard clock/data pins into the 16-bit keycode bus consumed by the digit comparator. It holds the last two accepted bytes as {previous, latest}, so a break sequence reads F0xx and a make code reads 00xx or yyxx in the low byte. It flags each new key press with a strobe and reports malformed frames. It sits between the board PS/2 pins and the game logic, in the single system clock domain.

---
 rtl/ps2_keycode_receiver.sv | 141 ++++++++++++++
 tb/tb_ps2_keycode_receiver.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ps2_keycode_receiver.sv
// PS/2 keyboard receiver: synchronises the keyboard pins, deserialises 11-bit frames
// and presents the last two good bytes as {previous, latest} with press/error strobes.
module ps2_keycode_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] keycode,
  output logic        byte_valid,
  output logic        make_strobe,
  output logic        frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [7:0]             shift_q, shift_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   parity_q, parity_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [15:0]            keycode_q, keycode_d;
  logic                   byte_valid_q, byte_valid_d;
  logic                   make_strobe_q, make_strobe_d;
  logic                   frame_error_q, frame_error_d;

  logic clk_s;
  logic data_s;
  logic fall;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = clk_prev_q & ~clk_s;

  always_comb begin
    clk_sync_d    = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d   = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_prev_d    = clk_s;
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    parity_d      = parity_q;
    timer_d       = timer_q;
    keycode_d     = keycode_q;
    byte_valid_d  = 1'b0;
    make_strobe_d = 1'b0;
    frame_error_d = 1'b0;

    if (state_q == S_IDLE) begin
      timer_d = '0;
      // A high level at the first falling edge is treated as a glitch, not a frame.
      if (fall && !data_s) begin
        state_d   = S_DATA;
        bit_cnt_d = 3'd0;
      end
    end else if (fall) begin
      timer_d = '0;
      case (state_q)
        S_DATA: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          parity_d = data_s;
          state_d  = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (data_s && (^{shift_q, parity_q})) begin
            keycode_d     = {keycode_q[7:0], shift_q};
            byte_valid_d  = 1'b1;
            make_strobe_d = (shift_q != 8'hF0) && (shift_q != 8'hE0) &&
                            (keycode_q[7:0] != 8'hF0);
          end else begin
            frame_error_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (timer_q == TIMER_LAST) begin
      frame_error_d = 1'b1;
      state_d       = S_IDLE;
      shift_d       = 8'hFF;
      bit_cnt_d     = 3'd0;
      timer_d       = '0;
    end else begin
      timer_d = timer_q + TIMER_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      clk_sync_q    <= '1;
      data_sync_q   <= '1;
      clk_prev_q    <= 1'b1;
      shift_q       <= 8'hFF;
      bit_cnt_q     <= 3'd0;
      parity_q      <= 1'b1;
      timer_q       <= '0;
      keycode_q     <= 16'h0000;
      byte_valid_q  <= 1'b0;
      make_strobe_q <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clk_sync_q    <= clk_sync_d;
      data_sync_q   <= data_sync_d;
      clk_prev_q    <= clk_prev_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      parity_q      <= parity_d;
      timer_q       <= timer_d;
      keycode_q     <= keycode_d;
      byte_valid_q  <= byte_valid_d;
      make_strobe_q <= make_strobe_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign keycode     = keycode_q;
  assign byte_valid  = byte_valid_q;
  assign make_strobe = make_strobe_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_keycode_receiver.sv
// Bench for ps2_keycode_receiver: drives PS/2 frames and compares pulse counts and
// keycode against a byte-level model of the keyboard protocol.
module tb_ps2_keycode_receiver;

  localparam int TO = 200;
  localparam int H  = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] keycode;
  logic        byte_valid;
  logic        make_strobe;
  logic        frame_error;

  int checks = 0;
  int errors = 0;
  int n_bv = 0, n_ms = 0, n_fe = 0;
  logic [15:0] model_kc = 16'h0000;

  ps2_keycode_receiver #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keycode(keycode), .byte_valid(byte_valid), .make_strobe(make_strobe),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  // Cumulative count of high cycles on each strobe.
  always @(negedge clk) begin
    if (byte_valid)  n_bv++;
    if (make_strobe) n_ms++;
    if (frame_error) n_fe++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached, CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  // Drives one frame and reports the strobe cycles it produced; also advances the model.
  task automatic exercise(input logic [7:0] b, input bit par_ok, input bit stop_ok,
                          output int dbv, output int dms, output int dfe,
                          output int ebv, output int ems, output int efe);
    int bv0, ms0, fe0;
    logic par;
    bv0 = n_bv; ms0 = n_ms; fe0 = n_fe;
    par = ~(^b);
    if (!par_ok) par = ~par;
    send_bits({stop_ok, par, b, 1'b0}, 11);
    repeat (2*H) @(negedge clk);
    dbv = n_bv - bv0; dms = n_ms - ms0; dfe = n_fe - fe0;
    ebv = 0; ems = 0; efe = 0;
    if (par_ok && stop_ok) begin
      ebv = 1;
      ems = (b != 8'hF0 && b != 8'hE0 && model_kc[7:0] != 8'hF0) ? 1 : 0;
      model_kc = {model_kc[7:0], b};
    end else begin
      efe = 1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (keycode !== 16'h0000) begin errors++; $display("FAIL reset_keycode got %h want 0000", keycode); end
    checks++;
    if ({byte_valid, make_strobe, frame_error} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes got %b want 000", {byte_valid, make_strobe, frame_error});
    end
    reset = 1'b0;
    model_kc = 16'h0000;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_sequence(input string name, input logic [7:0] bytes[],
                               input bit pok[], input bit sok[]);
    int dbv, dms, dfe, ebv, ems, efe;
    foreach (bytes[i]) begin
      exercise(bytes[i], pok[i], sok[i], dbv, dms, dfe, ebv, ems, efe);
      checks++;
      if (dbv !== ebv) begin errors++; $display("FAIL %s[%0d] byte_valid cycles got %0d want %0d", name, i, dbv, ebv); end
      checks++;
      if (dms !== ems) begin errors++; $display("FAIL %s[%0d] make_strobe cycles got %0d want %0d", name, i, dms, ems); end
      checks++;
      if (dfe !== efe) begin errors++; $display("FAIL %s[%0d] frame_error cycles got %0d want %0d", name, i, dfe, efe); end
      checks++;
      if (keycode !== model_kc) begin errors++; $display("FAIL %s[%0d] keycode got %h want %h", name, i, keycode, model_kc); end
    end
  endtask

  task automatic test_timeout();
    int bv0, fe0;
    logic [15:0] kc0;
    bv0 = n_bv; fe0 = n_fe; kc0 = model_kc;
    send_bits({2'b11, 8'h1E, 1'b0}, 5);
    repeat (TO + 20) @(negedge clk);
    checks++;
    if (n_fe - fe0 !== 1) begin errors++; $display("FAIL timeout frame_error cycles got %0d want 1", n_fe - fe0); end
    checks++;
    if (n_bv - bv0 !== 0) begin errors++; $display("FAIL timeout byte_valid cycles got %0d want 0", n_bv - bv0); end
    checks++;
    if (keycode !== kc0) begin errors++; $display("FAIL timeout keycode got %h want %h", keycode, kc0); end
    test_sequence("after_timeout", '{8'h1E}, '{1'b1}, '{1'b1});
  endtask

  task automatic test_async_reset();
    send_bits({2'b11, 8'h26, 1'b0}, 6);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (keycode !== 16'h0000) begin errors++; $display("FAIL async_reset keycode got %h want 0000", keycode); end
    checks++;
    if ({byte_valid, make_strobe, frame_error} !== 3'b000) begin
      errors++; $display("FAIL async_reset strobes got %b want 000", {byte_valid, make_strobe, frame_error});
    end
    model_kc = 16'h0000;
    ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    test_sequence("post_reset", '{8'h26}, '{1'b1}, '{1'b1});
  endtask

  task automatic test_random();
    logic [7:0] bytes[];
    bit pok[], sok[];
    int r;
    bytes = new[24]; pok = new[24]; sok = new[24];
    foreach (bytes[i]) begin
      r = $urandom_range(0, 9);
      bytes[i] = (r == 0) ? 8'hF0 : (r == 1) ? 8'hE0 : 8'($urandom);
      r = $urandom_range(0, 5);
      pok[i] = (r != 0);
      sok[i] = (r != 1);
    end
    test_sequence("random", bytes, pok, sok);
  endtask

  initial begin
    test_reset();
    test_sequence("single_16", '{8'h16}, '{1'b1}, '{1'b1});
    test_sequence("break", '{8'hF0, 8'h16}, '{1'b1, 1'b1}, '{1'b1, 1'b1});
    test_sequence("parity", '{8'h45, 8'h45}, '{1'b0, 1'b1}, '{1'b1, 1'b1});
    test_timeout();
    test_async_reset();
    test_sequence("extended", '{8'hE0, 8'h75, 8'h3C}, '{1'b1, 1'b1, 1'b1}, '{1'b1, 1'b1, 1'b0});
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
